// File: rtl/boss_bullet_unit.sv
`default_nettype none
// ============================================================================
// Module      : boss_bullet_unit
// Description : Spawns, homes, collides and draws the boss's single 2x2 bullet
//               once per frame on request from the top-level draw FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module boss_bullet_unit #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int BOSS_W   = 16,
    parameter int BOSS_H   = 12,
    parameter int PLAYER_W = 10,
    parameter int PLAYER_H = 10,
    parameter int VY       = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_boss,
    input  logic [6:0] y_boss,
    input  logic [7:0] x_player,
    input  logic [6:0] y_player,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       plot,
    output logic       player_collision,
    output logic       done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MOVE  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [8:0] C_XMAX     = 9'(SCREEN_W - 2);
    localparam logic [8:0] C_YMAX     = 9'(SCREEN_H - 3);
    localparam logic [8:0] C_SPAWN_DX = 9'(BOSS_W / 2 - 1);
    localparam logic [8:0] C_SPAWN_DY = 9'(BOSS_H);
    localparam logic [8:0] C_TGT_DX   = 9'(PLAYER_W / 2 - 1);
    localparam logic [8:0] C_PW_M1    = 9'(PLAYER_W - 1);
    localparam logic [8:0] C_PH_M1    = 9'(PLAYER_H - 1);
    localparam logic [8:0] C_VY       = 9'(VY);

    logic [2:0] r_state;
    logic [7:0] r_bx;
    logic [6:0] r_by;
    logic       r_active;
    logic [1:0] r_cnt;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic       r_plot;
    logic       r_coll;
    logic       r_done;

    logic [8:0] w_sx9;
    logic [8:0] w_sy9;
    logic [8:0] w_tx9;
    logic [8:0] w_by9;
    logic [8:0] w_bx9;
    logic [8:0] w_cbx9;
    logic [8:0] w_cby9;
    logic [8:0] w_px9;
    logic [8:0] w_py9;
    logic       w_hit;

    // All spawn/move/hit arithmetic is done 9 bits wide so sums never wrap.
    always_comb begin
        w_sx9 = {1'b0, x_boss} + C_SPAWN_DX;
        if (w_sx9 > C_XMAX) begin
            w_sx9 = C_XMAX;
        end
        w_sy9 = {2'b00, y_boss} + C_SPAWN_DY;
        w_tx9 = {1'b0, x_player} + C_TGT_DX;
        w_by9 = {2'b00, r_by} + C_VY;
        w_bx9 = {1'b0, r_bx};
        if (w_bx9 < w_tx9) begin
            w_bx9 = w_bx9 + 9'd1;
        end else if (w_bx9 > w_tx9) begin
            w_bx9 = w_bx9 - 9'd1;
        end
        if (w_bx9 > C_XMAX) begin
            w_bx9 = C_XMAX;
        end
        w_cbx9 = {1'b0, r_bx};
        w_cby9 = {2'b00, r_by};
        w_px9  = {1'b0, x_player};
        w_py9  = {2'b00, y_player};
        w_hit  = r_active
              && (w_cbx9 + 9'd1 >= w_px9) && (w_cbx9 <= w_px9 + C_PW_M1)
              && (w_cby9 + 9'd1 >= w_py9) && (w_cby9 <= w_py9 + C_PH_M1);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_bx     <= 8'd0;
            r_by     <= 7'd0;
            r_active <= 1'b0;
            r_cnt    <= 2'd0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_plot   <= 1'b0;
            r_coll   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            r_coll <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    r_done <= 1'b0;
                    if (!r_active) begin
                        if (w_sy9 <= C_YMAX) begin
                            r_bx     <= 8'(w_sx9);
                            r_by     <= 7'(w_sy9);
                            r_active <= 1'b1;
                        end
                    end else if (w_by9 > C_YMAX) begin
                        r_active <= 1'b0;
                    end else begin
                        r_by <= 7'(w_by9);
                        r_bx <= 8'(w_bx9);
                    end
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_hit) begin
                        r_active <= 1'b0;
                        r_coll   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (r_active) begin
                        r_cnt   <= 2'd0;
                        r_state <= S_DRAW;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DRAW: begin
                    r_plot <= 1'b1;
                    r_x    <= r_bx + {7'd0, r_cnt[0]};
                    r_y    <= r_by + {6'd0, r_cnt[1]};
                    r_cnt  <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    if (!start) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x                = r_x;
    assign y                = r_y;
    assign plot             = r_plot;
    assign player_collision = r_coll;
    assign done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_boss_bullet_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_boss_bullet_unit
// Description : Directed frame-by-frame bench for boss_bullet_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boss_bullet_unit;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [7:0] x_boss;
    logic [6:0] y_boss;
    logic [7:0] x_player;
    logic [6:0] y_player;
    logic [7:0] x;
    logic [6:0] y;
    logic       plot;
    logic       player_collision;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    boss_bullet_unit dut (
        .clock            (clock),
        .resetn           (resetn),
        .start            (start),
        .x_boss           (x_boss),
        .y_boss           (y_boss),
        .x_player         (x_player),
        .y_player         (y_player),
        .x                (x),
        .y                (y),
        .plot             (plot),
        .player_collision (player_collision),
        .done             (done)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full frame: raise start, collect plots/pulses until done, hold, release.
    task automatic run_frame(input string tag, input bit drawn, input int ex, input int ey,
                             input int ecoll, input int hold);
        int np, nc, cyc, bad;
        bit seen;
        int pxs[4];
        int pys[4];
        for (int i = 0; i < 4; i++) begin
            pxs[i] = -1;
            pys[i] = -1;
        end
        np = 0; nc = 0; cyc = 0; bad = 0; seen = 0;
        start = 1'b1;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (plot) begin
                if (np < 4) begin
                    pxs[np] = int'(x);
                    pys[np] = int'(y);
                end
                np++;
            end
            if (player_collision) nc++;
            if (done) seen = 1'b1;
        end
        check_eq({tag, " done_seen"}, int'(seen), 1);
        check_eq({tag, " done_latency"}, cyc, drawn ? 8 : 4);
        check_eq({tag, " plots"}, np, drawn ? 4 : 0);
        check_eq({tag, " collisions"}, nc, ecoll);
        if (drawn) begin
            for (int i = 0; i < 4; i++) begin
                check_eq({tag, $sformatf(" px%0d_x", i)}, pxs[i], ex + (i % 2));
                check_eq({tag, $sformatf(" px%0d_y", i)}, pys[i], ey + (i / 2));
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (plot || !done || player_collision) bad++;
        end
        check_eq({tag, " hold_violations"}, bad, 0);
        start = 1'b0;
        @(negedge clock);
        check_eq({tag, " done_after_release"}, int'(done), 1);
        @(negedge clock);
        check_eq({tag, " done_dropped"}, int'(done), 0);
        check_eq({tag, " idle_plot"}, int'(plot), 0);
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b1;
        x_boss   = 8'd70;
        y_boss   = 7'd10;
        x_player = 8'd20;
        y_player = 7'd100;

        repeat (2) @(negedge clock);
        check_eq("reset plot", int'(plot), 0);
        check_eq("reset done", int'(done), 0);
        check_eq("reset collision", int'(player_collision), 0);
        resetn = 1'b1;

        run_frame("spawn", 1'b1, 77, 22, 0, 0);
        run_frame("home1", 1'b1, 76, 24, 0, 0);
        run_frame("home2", 1'b1, 75, 26, 0, 0);

        x_player = 8'd70; y_player = 7'd20;
        run_frame("hit", 1'b0, 0, 0, 1, 0);
        x_player = 8'd20; y_player = 7'd100;
        run_frame("respawn", 1'b1, 77, 22, 0, 20);

        x_player = 8'd70; y_player = 7'd20;
        run_frame("hit2", 1'b0, 0, 0, 1, 0);
        x_player = 8'd20; y_player = 7'd100;
        y_boss = 7'd104;
        run_frame("low_spawn", 1'b1, 77, 116, 0, 0);
        run_frame("retire", 1'b0, 0, 0, 0, 0);
        y_boss = 7'd110;
        run_frame("no_spawn", 1'b0, 0, 0, 0, 0);
        y_boss = 7'd10;
        run_frame("spawn_again", 1'b1, 77, 22, 0, 0);

        // Abort the next frame with reset right after the first pixel.
        start = 1'b1;
        repeat (4) @(negedge clock);
        check_eq("pre_reset plot", int'(plot), 1);
        check_eq("pre_reset x", int'(x), 76);
        check_eq("pre_reset y", int'(y), 24);
        resetn = 1'b0;
        start  = 1'b0;
        @(negedge clock);
        check_eq("midreset plot", int'(plot), 0);
        check_eq("midreset done", int'(done), 0);
        resetn = 1'b1;
        @(negedge clock);
        run_frame("post_reset", 1'b1, 77, 22, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
